// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
//   Shared types and helpers for the pipelined ripple-carry adder/subtractor.
//   - op_e       : operation encoding carried on the op_sub port
//   - seg_width  : bits handled by one pipeline slice
//   - params_ok  : legality of a WIDTH/SEGMENTS pair, checked at elaboration
// -----------------------------------------------------------------------------
package adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    function automatic int seg_width(input int width, input int segments);
        return width / segments;
    endfunction

    function automatic bit params_ok(input int width, input int segments);
        return (width >= 2) && (segments >= 1) && (segments <= width) &&
               ((width % segments) == 0);
    endfunction

endpackage

// File: rtl/rca_segment.sv
// -----------------------------------------------------------------------------
// rca_segment
//   Purely combinational W-bit ripple-carry full-adder chain, one pipeline slice.
//   Ports:
//     a, b      in  [W-1:0]  slice operands (b already inverted for SUB)
//     ci        in  1        carry into bit 0 of the slice
//     s         out [W-1:0]  slice sum
//     co        out 1        carry out of the slice's top bit
//     c_msb_in  out 1        carry into the slice's top bit (for signed overflow)
// -----------------------------------------------------------------------------
module rca_segment #(
    parameter int W = 2
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         c_msb_in
);

    // c[i] is the carry into bit i; c[W] leaves the slice.
    logic [W:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co       = c[W];
    assign c_msb_in = c[W-1];

endmodule

// File: rtl/pipelined_rca_adder.sv
// -----------------------------------------------------------------------------
// pipelined_rca_adder
//   WIDTH-bit adder/subtractor whose carry chain is cut into SEGMENTS registered
//   slices. One beat per cycle, latency SEGMENTS cycles, results in order.
//   Ports:
//     clk, rst_n           clock, asynchronous active-low reset
//     in_valid / in_ready  operand handshake
//     a, b [WIDTH-1:0]     operands
//     cin                  carry in (ADD only)
//     op_sub               0 = a+b+cin, 1 = a-b (cin ignored)
//     out_valid/out_ready  result handshake
//     sum [WIDTH-1:0]      result modulo 2^WIDTH
//     cout                 carry out of MSB (SUB: 1 = no borrow)
//     ovf                  two's-complement overflow
//
//   Handshake: a beat transfers on any rising edge where valid && ready are both
//   high. The whole pipe advances together (adv = !out_valid || out_ready), so
//   in_ready equals adv and is purely combinational; valid never waits on ready.
//   When adv is low every stage, including the output, holds.
//
//   Stage k owns: its valid bit, the carry out of slice k, the low result slices
//   0..k (deskew) and the still-unused operand slices k+1.. (skew). Those skew
//   and deskew registers shrink/grow by one slice per stage, so stage widths
//   differ and each stage is its own generate block.
// -----------------------------------------------------------------------------
module pipelined_rca_adder
    import adder_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int SEGMENTS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SEG_W = seg_width(WIDTH, SEGMENTS);

    if (!params_ok(WIDTH, SEGMENTS)) begin : g_bad_params
        $error("pipelined_rca_adder: WIDTH must be >= 2 and divisible by SEGMENTS");
    end

    logic             adv;
    op_e              op;
    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic             ovf_q;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // SUB is a + ~b + 1: invert at acceptance so op_sub never needs to travel
    // past stage 0; the inverted operand slices carry the operation with them.
    assign op    = op_e'(op_sub);
    assign b_eff = (op == OP_SUB) ? ~b : b;
    assign c0    = (op == OP_SUB) ? 1'b1 : cin;

    for (genvar k = 0; k < SEGMENTS; k++) begin : g_stage
        localparam int OPW = WIDTH - k * SEG_W;  // operand bits entering stage k
        localparam int SW  = (k + 1) * SEG_W;    // result bits leaving stage k

        logic             src_v;
        logic             src_c;
        logic [OPW-1:0]   op_a;
        logic [OPW-1:0]   op_b;
        logic [SEG_W-1:0] seg_s;
        logic             seg_co;
        logic             seg_cm;
        logic             v_q;
        logic             c_q;
        logic [SW-1:0]    s_q;

        rca_segment #(.W(SEG_W)) u_seg (
            .a        (op_a[SEG_W-1:0]),
            .b        (op_b[SEG_W-1:0]),
            .ci       (src_c),
            .s        (seg_s),
            .co       (seg_co),
            .c_msb_in (seg_cm)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
            end else if (adv) begin
                v_q <= src_v;
                if (src_v) c_q <= seg_co;
            end
        end

        if (k == 0) begin : g_head
            assign src_v = in_valid;
            assign src_c = c0;
            assign op_a  = a;
            assign op_b  = b_eff;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)             s_q <= '0;
                else if (adv && src_v)  s_q <= seg_s;
            end
        end else begin : g_body
            assign src_v = g_stage[k-1].v_q;
            assign src_c = g_stage[k-1].c_q;
            assign op_a  = g_stage[k-1].g_skew.a_q;
            assign op_b  = g_stage[k-1].g_skew.b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)             s_q <= '0;
                else if (adv && src_v)  s_q <= {seg_s, g_stage[k-1].s_q};
            end
        end

        // The last stage has no upper slices left to forward.
        if (k < SEGMENTS - 1) begin : g_skew
            logic [OPW-SEG_W-1:0] a_q;
            logic [OPW-SEG_W-1:0] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv && src_v) begin
                    a_q <= op_a[OPW-1:SEG_W];
                    b_q <= op_b[OPW-1:SEG_W];
                end
            end
        end
    end

    // Overflow depends on carries around the word's MSB, which only the last
    // slice sees; register it alongside that stage's sum and carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_q <= 1'b0;
        else if (adv && g_stage[SEGMENTS-1].src_v)
            ovf_q <= g_stage[SEGMENTS-1].seg_cm ^ g_stage[SEGMENTS-1].seg_co;
    end

    assign out_valid = g_stage[SEGMENTS-1].v_q;
    assign sum       = g_stage[SEGMENTS-1].s_q;
    assign cout      = g_stage[SEGMENTS-1].c_q;
    assign ovf       = ovf_q;

endmodule
